// File: rtl/led_matrix_scan_ctrl.sv
// Serial-loaded, double-buffered, column-scanned LED matrix driver with PWM.
// Define LED_GAMMA_EN to map brightness through a gamma table.
module led_matrix_scan_ctrl #(
  parameter int ROWS  = 8,
  parameter int COLS  = 8,
  parameter int DWELL = 256,
  parameter int BLANK = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ena,
  input  logic            ser_data,
  input  logic            ser_clk,
  input  logic            ser_latch,
  input  logic [3:0]      brightness,
  output logic [ROWS-1:0] row_out,
  output logic [COLS-1:0] col_sel,
  output logic            frame_start,
  output logic            pending
);

  localparam int N    = ROWS * COLS;
  localparam int SLOT = (DWELL - BLANK) / 16;
  localparam int CW   = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int DW   = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam int SW   = (SLOT > 1) ? $clog2(SLOT) : 1;

  localparam logic [CW-1:0]   COL_LAST  = CW'(COLS - 1);
  localparam logic [DW-1:0]   DW_LAST   = DW'(DWELL - 1);
  localparam logic [DW-1:0]   BLANK_END = DW'(BLANK);
  localparam logic [SW-1:0]   SLOT_LAST = SW'(SLOT - 1);
  localparam logic [COLS-1:0] SEL_ONE   = COLS'(1);

  logic [2:0]      clk_sync;
  logic [2:0]      lat_sync;
  logic [1:0]      dat_sync;
  logic            shift_edge;
  logic            latch_edge;

  logic [N-1:0]    shift_reg;
  logic [N-1:0]    holding;
  logic [N-1:0]    display;

  logic [CW-1:0]   col;
  logic [DW-1:0]   dwell;
  logic [SW-1:0]   sub_cnt;
  logic [3:0]      slot;
  logic [3:0]      bri_q;
  logic [3:0]      bri_map;

  logic            boundary;
  logic            blank_ph;
  logic            dwell_wrap;
  logic [ROWS-1:0] col_slice;
  logic [ROWS-1:0] cols [COLS];

  // Data rides the same two-flop depth as the strobe it belongs to.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_sync <= '0;
      lat_sync <= '0;
      dat_sync <= '0;
    end else begin
      clk_sync <= {clk_sync[1:0], ser_clk};
      lat_sync <= {lat_sync[1:0], ser_latch};
      dat_sync <= {dat_sync[0], ser_data};
    end
  end

  assign shift_edge = clk_sync[1] & ~clk_sync[2];
  assign latch_edge = lat_sync[1] & ~lat_sync[2];

  assign boundary   = ena && (col == '0) && (dwell == '0);
  assign blank_ph   = dwell < BLANK_END;
  assign dwell_wrap = dwell == DW_LAST;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_reg <= '0;
      holding   <= '0;
      display   <= '0;
      pending   <= 1'b0;
    end else begin
      if (shift_edge) begin
        shift_reg <= {shift_reg[N-2:0], dat_sync[1]};
      end
      if (latch_edge) begin
        holding <= shift_reg;
      end
      if (boundary && pending) begin
        display <= holding;
      end
      // A latch landing on the boundary keeps the new frame waiting.
      if (latch_edge) begin
        pending <= 1'b1;
      end else if (boundary) begin
        pending <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col   <= '0;
      dwell <= '0;
    end else if (!ena) begin
      col   <= '0;
      dwell <= '0;
    end else if (dwell_wrap) begin
      dwell <= '0;
      col   <= (col == COL_LAST) ? '0 : col + 1'b1;
    end else begin
      dwell <= dwell + 1'b1;
    end
  end

  // Slot timing restarts at the first active cycle of every column.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sub_cnt <= '0;
      slot    <= '0;
    end else if (!ena || blank_ph || dwell_wrap) begin
      sub_cnt <= '0;
      slot    <= '0;
    end else if (sub_cnt == SLOT_LAST) begin
      sub_cnt <= '0;
      slot    <= slot + 1'b1;
    end else begin
      sub_cnt <= sub_cnt + 1'b1;
    end
  end

`ifdef LED_GAMMA_EN
  always_comb begin
    bri_map = 4'd0;
    case (brightness)
      4'd0:    bri_map = 4'd0;
      4'd1:    bri_map = 4'd0;
      4'd2:    bri_map = 4'd0;
      4'd3:    bri_map = 4'd1;
      4'd4:    bri_map = 4'd1;
      4'd5:    bri_map = 4'd2;
      4'd6:    bri_map = 4'd2;
      4'd7:    bri_map = 4'd3;
      4'd8:    bri_map = 4'd4;
      4'd9:    bri_map = 4'd5;
      4'd10:   bri_map = 4'd6;
      4'd11:   bri_map = 4'd7;
      4'd12:   bri_map = 4'd9;
      4'd13:   bri_map = 4'd11;
      4'd14:   bri_map = 4'd13;
      4'd15:   bri_map = 4'd15;
      default: bri_map = 4'd0;
    endcase
  end
`else
  always_comb begin
    bri_map = brightness;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bri_q <= '0;
    end else if (ena && (dwell == '0)) begin
      bri_q <= bri_map;
    end
  end

  for (genvar g = 0; g < COLS; g++) begin : g_col
    assign cols[g] = display[g*ROWS +: ROWS];
  end

  assign col_slice = cols[col];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_out     <= '0;
      col_sel     <= '0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= boundary;
      if (ena && !blank_ph) begin
        col_sel <= SEL_ONE << col;
        row_out <= (slot < bri_q) ? col_slice : '0;
      end else begin
        col_sel <= '0;
        row_out <= '0;
      end
    end
  end

endmodule

// File: tb/tb_led_matrix_scan_ctrl.sv
// Bench for led_matrix_scan_ctrl: per-column records are queued as expected
// results and matched against what the scan outputs actually produce.
`timescale 1ns/1ps
module tb_led_matrix_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b0;
  logic       ser_data = 1'b0;
  logic       ser_clk = 1'b0;
  logic       ser_latch = 1'b0;
  logic [3:0] brightness = 4'd0;
  logic [7:0] row_out;
  logic [7:0] col_sel;
  logic       frame_start;
  logic       pending;

  led_matrix_scan_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ena         (ena),
    .ser_data    (ser_data),
    .ser_clk     (ser_clk),
    .ser_latch   (ser_latch),
    .brightness  (brightness),
    .row_out     (row_out),
    .col_sel     (col_sel),
    .frame_start (frame_start),
    .pending     (pending)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] sel;
    logic [7:0] rows;
    int         hi;
    int         len;
    int         start;
  } rec_t;

  localparam logic [63:0] PAT_0 = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] PAT_A = 64'hA5C3_0F96_5A3C_F069;
  localparam logic [63:0] PAT_B = 64'h1E2D_3C4B_5A69_7887;
  localparam logic [63:0] PAT_C = 64'hC3C3_5A5A_F00F_0F1F;
  localparam logic [63:0] PAT_P = 64'h0000_0FFF_FFFF_FFFF;

  rec_t       sb_q[$];
  int         n_tests = 0;
  int         n_fail = 0;
  int         cyc = 0;
  int         fs_cyc = 0;
  int         blank_viol = 0;
  logic [7:0] cur_sel = 8'h00;
  logic [7:0] acc_rows = 8'h00;
  int         acc_hi = 0;
  int         acc_len = 0;
  int         acc_start = 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int bri_map(input int b);
`ifdef LED_GAMMA_EN
    int g[16] = '{0, 0, 0, 1, 1, 2, 2, 3, 4, 5, 6, 7, 9, 11, 13, 15};
    return g[b];
`else
    return b;
`endif
  endfunction

  task automatic push_col(input int c, input logic [7:0] slice, input int b);
    rec_t r;
    int   q;
    q       = bri_map(b);
    r.sel   = 8'(1 << c);
    r.rows  = (q != 0) ? slice : 8'h00;
    r.hi    = (r.rows != 8'h00) ? q * 15 : 0;
    r.len   = 240;
    r.start = 16 + 256 * c;
    sb_q.push_back(r);
  endtask

  task automatic push_frame(input logic [63:0] disp, input int b);
    for (int c = 0; c < 8; c++) push_col(c, disp[c*8 +: 8], b);
  endtask

  always @(posedge clk) cyc++;

  // One record per column: select, OR of rows, lit cycles, width, start.
  always @(negedge clk) begin
    rec_t e;
    if (frame_start) fs_cyc = cyc;
    if (col_sel != cur_sel) begin
      if (cur_sel != 8'h00 && sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk("col_sel", cur_sel, e.sel);
        chk("col_rows", acc_rows, e.rows);
        chk("col_on", acc_hi, e.hi);
        chk("col_width", acc_len, e.len);
        chk("col_start", acc_start, e.start);
      end
      cur_sel   = col_sel;
      acc_rows  = 8'h00;
      acc_hi    = 0;
      acc_len   = 0;
      acc_start = cyc - fs_cyc;
    end
    if (col_sel != 8'h00) begin
      acc_len++;
      acc_rows |= row_out;
      if (row_out != 8'h00) acc_hi++;
    end else if (row_out != 8'h00) begin
      blank_viol++;
    end
  end

  task automatic wait_frame(input int lim, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame_start && n < lim);
    chk("frame_start", frame_start, 1);
    #1;
  endtask

  task automatic drain(input int lim);
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < lim) begin
      @(negedge clk);
      n++;
    end
    chk("sb_drain", sb_q.size(), 0);
    sb_q.delete();
  endtask

  task automatic ser_send(input logic [63:0] v, input int nbits);
    for (int i = nbits - 1; i >= 0; i--) begin
      ser_data = v[i];
      ser_clk  = 1'b0;
      repeat (4) @(negedge clk);
      ser_clk  = 1'b1;
      repeat (4) @(negedge clk);
    end
    ser_clk = 1'b0;
  endtask

  task automatic latch();
    ser_latch = 1'b1;
    repeat (4) @(negedge clk);
    ser_latch = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    int n;
    int lit;
    int c0;

    brightness = 4'd15;
    repeat (3) @(negedge clk);
    chk("rst_row", row_out, 0);
    chk("rst_col", col_sel, 0);
    chk("rst_fs", frame_start, 0);
    chk("rst_pend", pending, 0);

    // scan order and wrap from reset
    ena   = 1'b1;
    rst_n = 1'b1;
    wait_frame(4, n);
    chk("fs_first", n, 1);
    push_frame(64'h0, 15);
    push_col(0, 8'h00, 15);
    drain(2600);

    // load a frame; it must wait for the boundary
    wait_frame(2100, n);
    ser_send(PAT_0, 64);
    latch();
    chk("pend_set", pending, 1);
    lit = 0;
    for (int i = 0; i < 2100 && !frame_start; i++) begin
      if (row_out != 8'h00) lit++;
      @(negedge clk);
    end
    chk("hold_old", lit, 0);
    chk("swap_fs", frame_start, 1);
    chk("pend_clr", pending, 0);
    #1;
    push_frame(PAT_0, 15);
    drain(2600);

    // brightness levels, changed mid-column
    ser_send('1, 64);
    latch();
    wait_frame(2100, n);
    push_col(0, 8'hFF, 15);
    push_col(1, 8'hFF, 8);
    push_col(2, 8'hFF, 0);
    push_col(3, 8'hFF, 2);
    repeat (100) @(negedge clk);
    brightness = 4'd8;
    repeat (256) @(negedge clk);
    brightness = 4'd0;
    repeat (256) @(negedge clk);
    brightness = 4'd2;
    drain(1200);
    brightness = 4'd15;

    // latch edge lands on the frame boundary
    wait_frame(2100, n);
    c0 = cyc;
    ser_send(PAT_A, 64);
    latch();
    ser_send(PAT_B, 64);
    while (cyc < c0 + 2045) @(negedge clk);
    ser_latch = 1'b1;
    wait_frame(8, n);
    chk("race_fs_at", n, 3);
    chk("race_pend", pending, 1);
    push_frame(PAT_A, 15);
    push_frame(PAT_B, 15);
    ser_latch = 1'b0;
    drain(4300);
    chk("race_pend_clr", pending, 0);

    // scan disabled mid-frame, serial port still live
    wait_frame(2100, n);
    repeat (300) @(negedge clk);
    ena = 1'b0;
    @(negedge clk);
    lit = 0;
    fork
      begin
        for (int i = 0; i < 1000; i++) begin
          if (row_out != 8'h00 || col_sel != 8'h00 || frame_start) lit++;
          @(negedge clk);
        end
      end
      begin
        ser_send(PAT_C, 64);
        latch();
      end
    join
    chk("off_quiet", lit, 0);
    chk("off_pend", pending, 1);
    ena = 1'b1;
    wait_frame(4, n);
    chk("reen_fs", n, 1);
    chk("reen_pend", pending, 0);
    push_frame(PAT_C, 15);
    drain(2300);

    // asynchronous reset mid-column and mid-shift
    wait_frame(2100, n);
    ser_send('1, 20);
    latch();
    chk("pre_rst_pend", pending, 1);
    for (int i = 0; i < 600 && row_out == 8'h00; i++) @(negedge clk);
    chk("pre_rst_lit", row_out != 8'h00, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_row", row_out, 0);
    chk("arst_col", col_sel, 0);
    chk("arst_pend", pending, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    wait_frame(4, n);
    push_frame(64'h0, 15);
    push_frame(PAT_P, 15);
    ser_send('1, 44);
    latch();
    drain(4300);
    chk("blank_dark", blank_viol, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
